mtm_alu_frame_serializer: RTL and testbench

Parametrised output serializer for the MTM ALU.
- Accepts one result word plus a control byte over a valid/ready handshake.
- Emits it on a single serial line as a sequence of 11-bit byte frames: start, packet-type, 8 data bits, stop.
- Generalises the fixed 32-bit, one-clock-per-bit serializer with configurable data width, a bit-period divider, input backpressure and a frame-completion strobe.
- Sits between the ALU core result register and the chip-level `sout` pin.

---
 rtl/mtm_alu_frame_serializer.sv | 161 ++++++++++++++++
 tb/tb_mtm_alu_frame_serializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_frame_serializer.sv
// mtm_alu_frame_serializer
//
// Takes one ALU result word and a control byte over a valid/ready handshake.
// Shifts them out on a single serial line as a sequence of 11-bit byte frames.
// Each byte frame is: start(0), packet bit, d[7]..d[0], stop(1).
// The packet bit is 1 only for the trailing CTL byte.
// in_ctl[7] = 1 selects an error frame, which carries the CTL byte alone.
//
// Parameters:
//   DATA_BYTES   result bytes per data frame (1..16)
//   CLKS_PER_BIT clock cycles per serial bit (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   in_data    ALU result word, most significant byte sent first
//   in_ctl     control/status byte; bit 7 selects the frame type
//   in_valid   in_data/in_ctl valid
//   in_ready   high only in IDLE; acceptance is in_valid && in_ready
//   sout       registered serial output, idles high
//   busy       frame in progress
//   frame_done one-cycle pulse in the last cycle of the final stop bit
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line idle (sout=1), waiting for in_valid
// S_START  | start bit (sout=0)
// S_PACKET | packet-type bit (1 for the CTL byte)
// S_DATA   | 8 data bits, MSB first, counted by bit_q
// S_STOP   | stop bit (sout=1); next byte or back to IDLE

module mtm_alu_frame_serializer #(
  parameter int DATA_BYTES   = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [7:0]              in_ctl,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    sout,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int SW = DW + 8;
  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BYTES + 2);

  localparam logic [PW-1:0] PER_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTES_DATA = BW'(DATA_BYTES + 1);
  localparam logic [BW-1:0] BYTES_ONE  = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PACKET,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_nx;
  logic [PW-1:0]   per_q, per_nx;
  logic [2:0]      bit_q, bit_nx;
  logic [BW-1:0]   byte_q, byte_nx;
  logic [SW-1:0]   shreg_q, shreg_nx;
  logic            sout_nx;
  logic            tick;

  assign tick = (per_q == PER_LAST);

  always_comb begin
    state_nx = state_q;
    per_nx   = per_q;
    bit_nx   = bit_q;
    byte_nx  = byte_q;
    shreg_nx = shreg_q;

    if (state_q != S_IDLE) begin
      per_nx = tick ? '0 : per_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_nx = S_START;
          per_nx   = '0;
          bit_nx   = '0;
          // Error frames park the CTL byte at the top so the same
          // MSB-first shifter emits it as the only byte.
          if (in_ctl[7]) begin
            shreg_nx = {in_ctl, {DW{1'b0}}};
            byte_nx  = BYTES_ONE;
          end else begin
            shreg_nx = {in_data, in_ctl};
            byte_nx  = BYTES_DATA;
          end
        end
      end
      S_START: begin
        if (tick) state_nx = S_PACKET;
      end
      S_PACKET: begin
        if (tick) begin
          state_nx = S_DATA;
          bit_nx   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_nx = {shreg_q[SW-2:0], 1'b0};
          bit_nx   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          byte_nx  = byte_q - 1'b1;
          state_nx = (byte_q == BYTES_ONE) ? S_IDLE : S_START;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // sout is registered, so it is decoded from the next-state values.
  always_comb begin
    sout_nx = 1'b1;
    case (state_nx)
      S_START:  sout_nx = 1'b0;
      S_PACKET: sout_nx = (byte_nx == BYTES_ONE);
      S_DATA:   sout_nx = shreg_nx[SW-1];
      default:  sout_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      per_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      sout    <= 1'b1;
    end else begin
      state_q <= state_nx;
      per_q   <= per_nx;
      bit_q   <= bit_nx;
      byte_q  <= byte_nx;
      shreg_q <= shreg_nx;
      sout    <= sout_nx;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_STOP) && tick && (byte_q == BYTES_ONE);

endmodule

// File: tb/tb_mtm_alu_frame_serializer.sv
module tb_mtm_alu_frame_serializer;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [7:0]  in_ctl;
  logic        in_valid;
  logic        in_ready, sout, busy, frame_done;

  logic [15:0] in_data2;
  logic [7:0]  in_ctl2;
  logic        in_valid2;
  logic        in_ready2, sout2, busy2, frame_done2;

  int n_checks = 0;
  int n_fail   = 0;

  mtm_alu_frame_serializer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_ctl(in_ctl),
    .in_valid(in_valid), .in_ready(in_ready), .sout(sout),
    .busy(busy), .frame_done(frame_done)
  );

  mtm_alu_frame_serializer #(.DATA_BYTES(2), .CLKS_PER_BIT(4)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_ctl(in_ctl2),
    .in_valid(in_valid2), .in_ready(in_ready2), .sout(sout2),
    .busy(busy2), .frame_done(frame_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  c;
    int          nbits;
    logic [54:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic capture(input int ncyc, input int drop_at,
                         input logic [31:0] d_mid, input logic [7:0] c_mid,
                         output logic [127:0] got, output int done_at,
                         output int done_cnt, output int busy_cnt);
    got = '0; done_at = 0; done_cnt = 0; busy_cnt = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (i == 1) begin
        in_data = d_mid;
        in_ctl  = c_mid;
      end
      if (i == drop_at) in_valid = 1'b0;
      got = {got[126:0], sout};
      if (frame_done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check(name, 128'({sout, busy, in_ready, frame_done}), 128'(4'b1010));
  endtask

  task automatic run_vec(input int k);
    logic [127:0] got;
    int done_at, done_cnt, busy_cnt;
    @(negedge clk);
    in_data  = vecs[k].d;
    in_ctl   = vecs[k].c;
    in_valid = 1'b1;
    @(posedge clk);
    // Flip the inputs (including the frame-type bit) once captured.
    capture(vecs[k].nbits, 1, ~vecs[k].d, vecs[k].c ^ 8'h80,
            got, done_at, done_cnt, busy_cnt);
    check($sformatf("vec%0d bits", k), got, 128'(vecs[k].exp));
    check($sformatf("vec%0d done_cycle", k), 128'(done_at), 128'(vecs[k].nbits));
    check($sformatf("vec%0d done_count", k), 128'(done_cnt), 128'(1));
    check($sformatf("vec%0d busy_cycles", k), 128'(busy_cnt), 128'(vecs[k].nbits));
    check_idle($sformatf("vec%0d idle_after", k));
  endtask

  initial begin
    logic [127:0] got;
    logic [127:0] exp_b2b;
    logic [32:0]  exp2;
    int done_at, done_cnt, busy_cnt, err2, cnt;
    logic bit_exp;

    vecs[0] = '{32'h12345678, 8'h0A, 55,
      55'b0_0_00010010_1_0_0_00110100_1_0_0_01010110_1_0_0_01111000_1_0_1_00001010_1};
    vecs[1] = '{32'hFFFFFFFF, 8'hC9, 11, 55'b0_1_11001001_1};
    vecs[2] = '{32'h00000000, 8'h00, 55,
      55'b0_0_00000000_1_0_0_00000000_1_0_0_00000000_1_0_0_00000000_1_0_1_00000000_1};
    vecs[3] = '{32'hFFFFFFFF, 8'h7F, 55,
      55'b0_0_11111111_1_0_0_11111111_1_0_0_11111111_1_0_0_11111111_1_0_1_01111111_1};
    vecs[4] = '{32'h12345678, 8'h80, 11, 55'b0_1_10000000_1};

    rst = 1'b1; in_data = '0; in_ctl = '0; in_valid = 1'b0;
    in_data2 = '0; in_ctl2 = '0; in_valid2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 128'({sout, busy, in_ready, frame_done}), 128'(4'b1010));
    check("reset_outputs2", 128'({sout2, busy2, in_ready2, frame_done2}), 128'(4'b1010));
    rst = 1'b0;
    check_idle("idle_after_reset");

    for (int k = 0; k < 5; k++) run_vec(k);

    // Back-to-back: valid held high, payload switched right after acceptance.
    @(negedge clk);
    in_data = 32'h12345678; in_ctl = 8'h0A; in_valid = 1'b1;
    @(posedge clk);
    capture(67, 57, 32'hDEADBEEF, 8'h95, got, done_at, done_cnt, busy_cnt);
    exp_b2b = 128'({vecs[0].exp, 1'b1, 11'b0_1_10010101_1});
    check("b2b bits", got, exp_b2b);
    check("b2b done_count", 128'(done_cnt), 128'(2));
    check("b2b first_done", 128'(done_at), 128'(55));
    check("b2b busy_cycles", 128'(busy_cnt), 128'(66));
    check_idle("b2b idle_after");

    // Reset during DATA bit 3 of byte 2 (cycle 17 after acceptance).
    @(negedge clk);
    in_data = 32'h12345678; in_ctl = 8'h0A; in_valid = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 1) in_valid = 1'b0;
    end
    check("midrst bit3_byte2", 128'({sout, busy}), 128'(2'b11));
    rst = 1'b1;
    @(negedge clk);
    check("midrst outputs", 128'({sout, busy, in_ready, frame_done}), 128'(4'b1010));
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_done || busy) cnt++;
    end
    check("midrst no_resume", 128'(cnt), 128'(0));
    run_vec(0);

    // Reset and valid together: nothing is accepted.
    @(negedge clk);
    rst = 1'b1; in_data = 32'h12345678; in_ctl = 8'h0A; in_valid = 1'b1;
    @(negedge clk);
    check("rst_valid in_reset", 128'({sout, busy, in_ready}), 128'(3'b101));
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_valid not_accepted", 128'({sout, busy, in_ready}), 128'(3'b101));

    // CLKS_PER_BIT=4, DATA_BYTES=2 instance.
    exp2 = 33'b0_0_10100101_1_0_0_01011010_1_0_1_00000000_1;
    @(negedge clk);
    in_data2 = 16'hA55A; in_ctl2 = 8'h00; in_valid2 = 1'b1;
    @(posedge clk);
    err2 = 0; busy_cnt = 0; done_at = 0; done_cnt = 0;
    for (int i = 1; i <= 132; i++) begin
      @(negedge clk);
      if (i == 1) begin
        in_valid2 = 1'b0;
        in_data2  = 16'h0000;
        in_ctl2   = 8'hFF;
      end
      bit_exp = exp2[32 - (i - 1) / 4];
      if (sout2 !== bit_exp) err2++;
      if (busy2) busy_cnt++;
      if (frame_done2) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
    end
    check("p4x2 bit_errors", 128'(err2), 128'(0));
    check("p4x2 busy_cycles", 128'(busy_cnt), 128'(132));
    check("p4x2 done_cycle", 128'(done_at), 128'(132));
    check("p4x2 done_count", 128'(done_cnt), 128'(1));
    @(negedge clk);
    check("p4x2 idle_after", 128'({sout2, busy2, in_ready2, frame_done2}), 128'(4'b1010));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
